// File: rtl/control_fsm_pkg.sv
// Shared types for the accumulator CPU control path.
//   alu_functions_t : ALU function select driven to the datapath
//   PcSel_t         : next-PC source (increment or jump target)
//   opcode_t        : instruction opcode field IR[7:4]
//   ctrl_state_t    : sequencer states
//   ctrl_word_t     : decoded control word for one execute cycle
package opcodes;

  typedef enum logic [2:0] {
    ALU_A   = 3'd0,
    ALU_B   = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_NOT = 3'd7
  } alu_functions_t;

  typedef enum logic {
    PcInc = 1'b0,
    PcJmp = 1'b1
  } PcSel_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDIL = 4'h1,
    OP_LDIH = 4'h2,
    OP_ADDI = 4'h3,
    OP_ADD  = 4'h4,
    OP_LD   = 4'h5,
    OP_ST   = 4'h6,
    OP_IN   = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic           reg_we;
    logic           imm_sel;
    logic           wdata_sel;
    logic           acc_we;
    logic           op1_sel;
    logic           pc_we;
    alu_functions_t alu_op;
    PcSel_t         pc_sel;
    logic           illegal;
    logic           halt;
  } ctrl_word_t;

  // Quiescent control word: nothing written, ALU passes A, PC would increment.
  localparam ctrl_word_t CTRL_IDLE = '{
    reg_we:    1'b0,
    imm_sel:   1'b0,
    wdata_sel: 1'b0,
    acc_we:    1'b0,
    op1_sel:   1'b0,
    pc_we:     1'b0,
    alu_op:    ALU_A,
    pc_sel:    PcInc,
    illegal:   1'b0,
    halt:      1'b0
  };

endpackage

// File: rtl/control_fsm_decode.sv
// control_decode: combinational opcode -> control word.
//   Opcode   in   4   IR[7:4] of the latched instruction
//   AccZero  in   1   accumulator == 0 (only with COND_BRANCH_EN)
//   Cw       out  ctrl_word_t  control word for the execute cycle
// Optional feature macro: COND_BRANCH_EN (adds JZ, opcode 9).
module control_decode
  import opcodes::*;
(
  input  logic [3:0] Opcode,
`ifdef COND_BRANCH_EN
  input  logic       AccZero,
`endif
  output ctrl_word_t Cw
);

  always_comb begin
    Cw       = CTRL_IDLE;
    // Every instruction advances the PC unless it overrides below.
    Cw.pc_we = 1'b1;
    case (Opcode)
      OP_NOP: ;
      OP_LDIL: begin
        Cw.op1_sel = 1'b1;
        Cw.acc_we  = 1'b1;
      end
      OP_LDIH: begin
        Cw.op1_sel = 1'b1;
        Cw.imm_sel = 1'b1;
        Cw.acc_we  = 1'b1;
      end
      OP_ADDI: begin
        Cw.op1_sel = 1'b1;
        Cw.alu_op  = ALU_ADD;
        Cw.acc_we  = 1'b1;
      end
      OP_ADD: begin
        Cw.alu_op = ALU_ADD;
        Cw.acc_we = 1'b1;
      end
      OP_LD: begin
        Cw.acc_we = 1'b1;
      end
      OP_ST: begin
        Cw.reg_we = 1'b1;
      end
      OP_IN: begin
        Cw.reg_we    = 1'b1;
        Cw.wdata_sel = 1'b1;
      end
      OP_JMP: begin
        Cw.pc_sel = PcJmp;
      end
`ifdef COND_BRANCH_EN
      OP_JZ: begin
        Cw.pc_sel = AccZero ? PcJmp : PcInc;
      end
`endif
      OP_HALT: begin
        Cw.pc_we = 1'b0;
        Cw.halt  = 1'b1;
      end
      // Undefined opcodes behave as NOP but are flagged.
      default: begin
        Cw.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: two-cycle instruction sequencer for the 8-bit accumulator CPU.
// Latches the instruction in S_FETCH, drives datapath strobes in S_EXEC,
// and parks in S_HALT after a HALT instruction until nReset.
//   Clock     in   1   system clock (rising edge)
//   nReset    in   1   asynchronous active-low reset
//   MemData   in   n   instruction word at current Pc
//   Stall     in   1   hold sequencer, mask all write enables
//   AccZero   in   1   accumulator == 0 (only with COND_BRANCH_EN)
//   RegWe, ImmSel, WDataSel, AccWe, Op1Sel, PcWe   out  datapath strobes
//   AluOp     out  alu_functions_t
//   PcSel     out  PcSel_t
//   Halted    out  1   high while halted
//   IllegalOp out  1   pulse on execute of an undefined opcode
// Optional feature macro: COND_BRANCH_EN (AccZero port, JZ instruction).
module control_fsm
  import opcodes::*;
#(
  parameter int n = 8
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic [n-1:0]   MemData,
  input  logic           Stall,
`ifdef COND_BRANCH_EN
  input  logic           AccZero,
`endif
  output logic           RegWe,
  output logic           ImmSel,
  output logic           WDataSel,
  output logic           AccWe,
  output logic           Op1Sel,
  output logic           PcWe,
  output alu_functions_t AluOp,
  output PcSel_t         PcSel,
  output logic           Halted,
  output logic           IllegalOp
);

  ctrl_state_t state;
  logic [n-1:0] ir;
  ctrl_word_t   cw;
  // The operand nibble is consumed by the datapath straight from MemData,
  // which stays valid because Pc only moves at the end of S_EXEC.
  logic         unused_operand;

  assign unused_operand = ^ir[n-5:0];

  control_decode u_decode (
    .Opcode  (ir[n-1:n-4]),
`ifdef COND_BRANCH_EN
    .AccZero (AccZero),
`endif
    .Cw      (cw)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!Stall) begin
            ir    <= MemData;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!Stall) begin
            state <= cw.halt ? S_HALT : S_FETCH;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Outputs depend only on registered state/IR; Stall masks the write
  // enables combinationally so a stalled execute cycle writes nothing.
  always_comb begin
    RegWe     = 1'b0;
    ImmSel    = 1'b0;
    WDataSel  = 1'b0;
    AccWe     = 1'b0;
    Op1Sel    = 1'b0;
    PcWe      = 1'b0;
    AluOp     = ALU_A;
    PcSel     = PcInc;
    IllegalOp = 1'b0;
    if (state == S_EXEC) begin
      ImmSel    = cw.imm_sel;
      WDataSel  = cw.wdata_sel;
      Op1Sel    = cw.op1_sel;
      AluOp     = cw.alu_op;
      PcSel     = cw.pc_sel;
      RegWe     = cw.reg_we  & ~Stall;
      AccWe     = cw.acc_we  & ~Stall;
      PcWe      = cw.pc_we   & ~Stall;
      IllegalOp = cw.illegal & ~Stall;
    end
  end

  assign Halted = (state == S_HALT);

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
  import opcodes::*;

  logic           Clock = 1'b0;
  logic           nReset = 1'b1;
  logic [7:0]     MemData = 8'h00;
  logic           Stall = 1'b0;
  logic           AccZero = 1'b0;
  logic           RegWe, ImmSel, WDataSel, AccWe, Op1Sel, PcWe;
  alu_functions_t AluOp;
  PcSel_t         PcSel;
  logic           Halted, IllegalOp;

  int passed = 0;
  int total  = 0;

  // Reference model: where we are in the two-cycle instruction, and whether halted.
  bit         m_in_exec = 1'b0;
  bit         m_halted  = 1'b0;
  logic [7:0] m_instr   = 8'h00;

`ifndef COND_BRANCH_EN
  logic unused_az;
  assign unused_az = AccZero;
`endif

  control_fsm #(.n(8)) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .MemData   (MemData),
    .Stall     (Stall),
`ifdef COND_BRANCH_EN
    .AccZero   (AccZero),
`endif
    .RegWe     (RegWe),
    .ImmSel    (ImmSel),
    .WDataSel  (WDataSel),
    .AccWe     (AccWe),
    .Op1Sel    (Op1Sel),
    .PcWe      (PcWe),
    .AluOp     (AluOp),
    .PcSel     (PcSel),
    .Halted    (Halted),
    .IllegalOp (IllegalOp)
  );

  always #5 Clock = ~Clock;

  // Expected outputs packed as {RegWe,ImmSel,WDataSel,AccWe,Op1Sel,PcWe,AluOp,PcSel,Halted,IllegalOp}.
  function automatic logic [11:0] expected_outputs(bit in_reset, bit in_exec, bit halted,
                                                   logic [7:0] instr, bit stall);
    logic rw, is, ws, aw, os, pw, hl, il;
    alu_functions_t alu;
    PcSel_t ps;
    rw = 0; is = 0; ws = 0; aw = 0; os = 0; pw = 0; hl = 0; il = 0;
    alu = ALU_A; ps = PcInc;
    if (!in_reset && halted) begin
      hl = 1;
    end else if (!in_reset && in_exec) begin
      pw = 1;
      case (instr[7:4])
        4'h0: ;
        4'h1: begin os = 1; aw = 1; end
        4'h2: begin os = 1; is = 1; aw = 1; end
        4'h3: begin os = 1; alu = ALU_ADD; aw = 1; end
        4'h4: begin alu = ALU_ADD; aw = 1; end
        4'h5: aw = 1;
        4'h6: rw = 1;
        4'h7: begin rw = 1; ws = 1; end
        4'h8: ps = PcJmp;
`ifdef COND_BRANCH_EN
        4'h9: ps = AccZero ? PcJmp : PcInc;
`endif
        4'hF: pw = 0;
        default: il = 1;
      endcase
      if (stall) begin
        rw = 0; aw = 0; pw = 0; il = 0;
      end
    end
    return {rw, is, ws, aw, os, pw, alu, ps, hl, il};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: outputs got %03h expected %03h", tag, obs, exp);
  endtask

  // One clock cycle: drive at negedge, check shortly after, advance model at posedge.
  task automatic cycle(input string tag, input logic [7:0] mem, input bit stall,
                       input bit az, input bit rst_low);
    @(negedge Clock);
    MemData = mem;
    Stall   = stall;
    AccZero = az;
    nReset  = rst_low ? 1'b0 : 1'b1;
    #1;
    if (rst_low) begin
      m_in_exec = 0;
      m_halted  = 0;
    end
    check(tag, {RegWe, ImmSel, WDataSel, AccWe, Op1Sel, PcWe, AluOp, PcSel, Halted, IllegalOp},
          expected_outputs(rst_low, m_in_exec, m_halted, m_instr, stall));
    @(posedge Clock);
    if (!rst_low && !m_halted && !stall) begin
      if (!m_in_exec) begin
        m_instr   = mem;
        m_in_exec = 1;
      end else begin
        m_in_exec = 0;
        if (m_instr[7:4] == 4'hF) m_halted = 1;
      end
    end
  endtask

  initial begin
    logic [7:0] rmem;
    bit rstall, raz, rrst;

    // Asynchronous reset asserted between edges.
    #2 nReset = 1'b0;
    #1;
    check("reset_async", {RegWe, ImmSel, WDataSel, AccWe, Op1Sel, PcWe, AluOp, PcSel, Halted, IllegalOp},
          12'h000);
    cycle("reset_hold0", 8'h00, 0, 0, 1);
    cycle("reset_hold1", 8'h00, 0, 0, 1);

    // LDIL: fetch then execute, then idle fetch.
    cycle("ldil_fetch", 8'h15, 0, 0, 0);
    cycle("ldil_exec",  8'h15, 0, 0, 0);
    // ST then IN.
    cycle("st_fetch",   8'h60, 0, 0, 0);
    cycle("st_exec",    8'h60, 0, 0, 0);
    cycle("in_fetch",   8'h71, 0, 0, 0);
    cycle("in_exec",    8'h71, 0, 0, 0);
    // ADDI stalled three cycles in execute.
    cycle("addi_fetch", 8'h33, 0, 0, 0);
    cycle("addi_stall0", 8'h33, 1, 0, 0);
    cycle("addi_stall1", 8'h33, 1, 0, 0);
    cycle("addi_stall2", 8'h33, 1, 0, 0);
    cycle("addi_exec",  8'h33, 0, 0, 0);
    cycle("after_addi", 8'h00, 0, 0, 0);
    // Undefined opcode.
    cycle("illegal_exec", 8'h00, 0, 0, 0);
    cycle("illop_fetch", 8'hA0, 0, 0, 0);
    cycle("illop_exec",  8'hA0, 0, 0, 0);
    // JMP and branch opcode 9.
    cycle("jmp_fetch",  8'h85, 0, 0, 0);
    cycle("jmp_exec",   8'h85, 0, 0, 0);
    cycle("jz_fetch",   8'h90, 0, 1, 0);
    cycle("jz_exec_z",  8'h90, 0, 1, 0);
    cycle("jz_fetch2",  8'h90, 0, 0, 0);
    cycle("jz_exec_nz", 8'h90, 0, 0, 0);
    // Reset in the middle of an LDIL execute abandons it.
    cycle("abort_fetch", 8'h15, 0, 0, 0);
    cycle("abort_rst",   8'h15, 0, 0, 1);
    cycle("abort_rst2",  8'h15, 0, 0, 1);
    cycle("abort_post",  8'h15, 0, 0, 0);
    cycle("abort_reexec", 8'h15, 0, 0, 0);

    // Randomised instruction stream with stalls, rare halts and resets.
    for (int i = 0; i < 400; i++) begin
      rmem = 8'($urandom);
      if (rmem[7:4] == 4'hF && $urandom_range(0, 7) != 0) rmem[7:4] = 4'h0;
      rstall = ($urandom_range(0, 3) == 0);
      raz    = 1'($urandom);
      rrst   = ($urandom_range(0, 29) == 0);
      cycle("random", rmem, rstall, raz, rrst);
    end

    // HALT is sticky and ignores Stall/MemData until reset.
    cycle("halt_rst",   8'h00, 0, 0, 1);
    cycle("halt_fetch", 8'hF0, 0, 0, 0);
    cycle("halt_exec",  8'hF0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle("halted", 8'($urandom), 1'($urandom), 1'($urandom), 0);
    end
    cycle("halt_exit_rst", 8'h15, 0, 0, 1);
    cycle("halt_exit_fetch", 8'h15, 0, 0, 0);
    cycle("halt_exit_exec",  8'h15, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
